// File: rtl/nios_fprint_sysid_pkg.sv
// Shared definitions for the system-ID fingerprint reader.
// Contents:
//   state_t             - reader FSM states
//   ID_OFS / TS_OFS     - byte offsets of the ID and timestamp words
//   DEFAULT_EXPECTED_*  - fingerprint values the reader checks against by default
//   STALL_W             - width of the per-read stall counter
package nios_fprint_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [31:0] ID_OFS = 32'd0;
  localparam logic [31:0] TS_OFS = 32'd4;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1432315598;  // 0x555F66CE

  localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/nios_fprint_stall_timer.sv
// Counts stalled cycles of a single bus read.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high reset, clears the count
//   clear   - clears the count (wins over enable)
//   enable  - increment by one this cycle
//   limit   - count value at which the read is considered timed out
//   expired - count has reached limit
module nios_fprint_stall_timer
  import nios_fprint_sysid_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [STALL_W-1:0] limit,
  output logic               expired
);

  logic [STALL_W-1:0] count;

  // Counting stops once the limit is reached, so the counter cannot wrap.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= limit);

endmodule

// File: rtl/nios_fprint_sysid_reader.sv
// Reads the two words of a system-ID slave (ID at BASE_ADDR, timestamp at
// BASE_ADDR+4) over Avalon-MM and compares them with the expected fingerprint.
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   start                - pulse that launches a check sequence (ignored unless idle)
//   busy                 - a read is in progress
//   done                 - one-cycle pulse at the end of a sequence
//   id_ok, ts_ok         - captured words match EXPECTED_ID / EXPECTED_TS
//   timeout_err          - a read stalled beyond TIMEOUT_CYCLES
//   id_value, ts_value   - captured words
//   avm_*                - Avalon-MM read master
//   fsm_state            - current FSM state, for observation
//
// Handshake: a read is offered by holding avm_read=1 with a fixed avm_address;
// it completes in the cycle the slave shows avm_waitrequest=0, and
// avm_readdata is sampled in that same cycle. While avm_waitrequest=1 the
// request stays unchanged, unless the stall timer expires and the read is
// abandoned.
module nios_fprint_sysid_reader
  import nios_fprint_sysid_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output state_t      fsm_state
);

  state_t state;
  state_t next_state;

  logic in_read;
  logic accept;
  logic stall_expired;
  logic time_out;

  assign in_read  = (state == RD_ID) || (state == RD_TS);
  assign accept   = in_read && !avm_waitrequest;
  assign time_out = in_read && avm_waitrequest && stall_expired;

  // The counter is held clear outside the read states and on each completed
  // read, so it starts from zero on entry to RD_ID and to RD_TS.
  nios_fprint_stall_timer u_stall_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_read || accept),
    .enable  (in_read && avm_waitrequest),
    .limit   (STALL_W'(TIMEOUT_CYCLES)),
    .expired (stall_expired)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a timeout in RD_ID skips the timestamp read entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RD_ID;
      RD_ID:   if (accept) next_state = RD_TS;
               else if (time_out) next_state = FIN;
      RD_TS:   if (accept || time_out) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from state only, so address and read cannot move
  // while the slave stalls.
  always_comb begin
    busy        = in_read;
    done        = (state == FIN);
    avm_read    = in_read;
    avm_address = (state == RD_TS) ? (BASE_ADDR + TS_OFS) : (BASE_ADDR + ID_OFS);
    fsm_state   = state;
  end

  // Result registers. The ok flags are resolved on the way into FIN so they
  // are already valid in the done cycle; a word that was never captured
  // leaves its flag at the 0 it was cleared to on start.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end
        RD_ID: begin
          if (accept) begin
            id_value <= avm_readdata;
          end else if (time_out) begin
            timeout_err <= 1'b1;
          end
        end
        RD_TS: begin
          if (accept) begin
            ts_value <= avm_readdata;
            ts_ok    <= (avm_readdata == EXPECTED_TS);
            id_ok    <= (id_value == EXPECTED_ID);
          end else if (time_out) begin
            timeout_err <= 1'b1;
            id_ok       <= (id_value == EXPECTED_ID);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_fprint_sysid_reader.sv
module tb_nios_fprint_sysid_reader;
  import nios_fprint_sysid_pkg::*;

  localparam logic [31:0] BASE   = 32'h0000_1A40;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'h555F_66CE;
  localparam int          T      = 16;
  localparam int          STUCK  = 1000;
  localparam int          BUDGET = 80;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  state_t      fsm_state;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  nios_fprint_sysid_reader #(
    .BASE_ADDR      (BASE),
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout_err     (timeout_err),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .fsm_state       (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Reference model: outcome of one sequence from the slave's stall counts and
  // data. A read times out when it is stalled for more than T cycles.
  task automatic model_push(input int w0, input int w1,
                            input logic [31:0] d0, input logic [31:0] d1);
    bit to0, to1;
    to0 = (w0 > T);
    to1 = !to0 && (w1 > T);
    exp_q.push_back(to0 ? T + 2 : (to1 ? w0 + T + 3 : w0 + w1 + 3)); // done cycle
    exp_q.push_back(to0 ? 0 : (to1 ? 1 : 2));                        // handshakes
    exp_q.push_back(32'(!to0 && d0 == EXP_ID));                      // id_ok
    exp_q.push_back(32'(!to0 && !to1 && d1 == EXP_TS));              // ts_ok
    exp_q.push_back(32'(to0 || to1));                                // timeout_err
    exp_q.push_back(to0 ? 32'd0 : d0);                               // id_value
    exp_q.push_back((to0 || to1) ? 32'd0 : d1);                      // ts_value
  endtask

  // ---------------- driver ----------------
  // Runs one sequence with start in cycle 0, acting as the slave. dup_at > 0
  // repeats start in that cycle (while busy); start_in_fin pulses start in the
  // done cycle. Both must be ignored.
  task automatic run_seq(input int w0, input int w1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input int dup_at, input bit start_in_fin);
    int done_cycle, hs, busy_err, hold_err, addr_err, stall_left, stalled;
    int extra_done, idle_busy;
    bit prev_stall, prev_read;
    logic [31:0] prev_addr;
    logic [31:0] e_done, e_hs, e_idok, e_tsok, e_to, e_idv, e_tsv;

    model_push(w0, w1, d0, d1);
    done_cycle = -1; hs = 0; busy_err = 0; hold_err = 0; addr_err = 0;
    stall_left = 0; stalled = 0; prev_stall = 0; prev_read = 0; prev_addr = '0;

    @(negedge clock);
    start = 1'b1;
    avm_waitrequest = 1'b0;
    for (int c = 1; c <= BUDGET && done_cycle < 0; c++) begin
      @(negedge clock);
      start = (c == dup_at);
      if (prev_stall && stalled <= T && (!avm_read || avm_address != prev_addr)) hold_err++;
      if (done) begin
        done_cycle = c;
        if (busy || avm_read) busy_err++;
        avm_waitrequest = 1'b0;
        start = start_in_fin;
      end else begin
        if (!busy || !avm_read) busy_err++;
        if (avm_read && (!prev_read || avm_address != prev_addr)) begin
          stall_left = (avm_address == BASE) ? w0 : w1;
          stalled = 0;
        end
        if (avm_address != BASE && avm_address != BASE + 32'd4) addr_err++;
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          avm_readdata = $urandom;
          stall_left--;
          stalled++;
        end else begin
          avm_waitrequest = 1'b0;
          avm_readdata = (avm_address == BASE) ? d0 : d1;
          if (avm_read) hs++;
        end
        prev_stall = avm_waitrequest;
        prev_read = avm_read;
        prev_addr = avm_address;
      end
    end

    e_done = exp_q.pop_front(); e_hs = exp_q.pop_front();
    e_idok = exp_q.pop_front(); e_tsok = exp_q.pop_front();
    e_to = exp_q.pop_front(); e_idv = exp_q.pop_front(); e_tsv = exp_q.pop_front();

    check_eq("done_cycle", done_cycle, e_done);
    if (done_cycle >= 0) begin
      check_eq("handshakes", hs, e_hs);
      check_eq("id_ok", {31'd0, id_ok}, e_idok);
      check_eq("ts_ok", {31'd0, ts_ok}, e_tsok);
      check_eq("timeout_err", {31'd0, timeout_err}, e_to);
      check_eq("id_value", id_value, e_idv);
      check_eq("ts_value", ts_value, e_tsv);
      check_eq("busy_read_shape", busy_err, 0);
      check_eq("req_stable", hold_err, 0);
      check_eq("addr_range", addr_err, 0);
    end

    // Results must hold while idle, with no further activity.
    extra_done = 0; idle_busy = 0;
    repeat (4) begin
      @(negedge clock);
      start = 1'b0;
      if (done) extra_done++;
      if (busy || avm_read) idle_busy++;
    end
    check_eq("extra_done", extra_done, 0);
    check_eq("idle_busy", idle_busy, 0);
    check_eq("hold_id_value", id_value, e_idv);
    check_eq("hold_ts_ok", {31'd0, ts_ok}, e_tsok);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_read"}, {31'd0, avm_read}, 32'd0);
    check_eq({tag, "_addr"}, avm_address, BASE);
    check_eq({tag, "_oks"}, {29'd0, id_ok, ts_ok, timeout_err}, 32'd0);
    check_eq({tag, "_id_value"}, id_value, 32'd0);
    check_eq({tag, "_ts_value"}, ts_value, 32'd0);
  endtask

  // Reset while the timestamp read is stalled.
  task automatic reset_in_ts();
    bit found;
    found = 0;
    @(negedge clock);
    start = 1'b1;
    avm_waitrequest = 1'b0;
    for (int c = 1; c <= 10 && !found; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (avm_read && avm_address == BASE + 32'd4) begin
        found = 1;
        reset = 1'b1;
        avm_waitrequest = 1'b1;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata = 32'hDEAD_0001;
      end
    end
    check_eq("reach_rd_ts", {31'd0, found}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    check_cleared("rst_mid");
  endtask

  // ---------------- main ----------------
  initial begin
    int w0, w1, dup, r;
    logic [31:0] d0, d1;

    reset = 1'b1; start = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0;
    repeat (3) @(negedge clock);
    check_cleared("rst");
    check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
    reset = 1'b0;

    run_seq(0, 0, 32'd0, EXP_TS, 0, 0);          // zero-wait, both match
    run_seq(0, 0, 32'd1, EXP_TS, 0, 0);          // wrong ID
    run_seq(3, 3, EXP_ID, EXP_TS, 0, 0);         // 3 stalls per read
    run_seq(STUCK, STUCK, EXP_ID, EXP_TS, 0, 0); // stuck slave
    run_seq(0, STUCK, 32'd7, EXP_TS, 0, 0);      // timeout on timestamp only
    run_seq(T, T, EXP_ID, EXP_TS, 0, 0);         // longest non-timeout stall
    run_seq(2, 0, EXP_ID, EXP_TS, 2, 1);         // start while busy and in FIN

    reset_in_ts();
    run_seq(1, 2, EXP_ID, EXP_TS, 0, 0);

    // start coincident with reset is dropped
    @(negedge clock);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    check_eq("rst_start_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      w0 = (r < 6) ? $urandom_range(0, 4) : ((r < 8) ? $urandom_range(T - 1, T + 2) : STUCK);
      r  = $urandom_range(0, 9);
      w1 = (r < 6) ? $urandom_range(0, 4) : ((r < 8) ? $urandom_range(T - 1, T + 2) : STUCK);
      d0 = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      d1 = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
      dup = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, ((w0 > T) ? T : w0) + 1);
      run_seq(w0, w1, d0, d1, dup, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nios_fprint_sysid_reader.md
NIOS_FPRINT_SYSID_READER -- requirements
Module: nios_fprint_sysid_reader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the system-ID slave.
REQ-002 Parameter EXPECTED_ID, default 32'd0, value word 0 SHALL hold.
REQ-003 Parameter EXPECTED_TS, default 32'd1432315598 (0x555F66CE), value word 1 SHALL hold.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, maximum stall cycles per read, range 1..65535.
REQ-005 clock  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse that launches a check sequence.
REQ-008 busy  out  1  high while a sequence is in progress.
REQ-009 done  out  1  one-cycle pulse when a sequence ends.
REQ-010 id_ok  out  1  word 0 equals EXPECTED_ID; valid from done until next start.
REQ-011 ts_ok  out  1  word 1 equals EXPECTED_TS; same validity as id_ok.
REQ-012 timeout_err  out  1  a read exceeded TIMEOUT_CYCLES; same validity as id_ok.
REQ-013 id_value  out  32  captured word 0.
REQ-014 ts_value  out  32  captured word 1.
REQ-015 avm_address  out  32  byte address: BASE_ADDR or BASE_ADDR+4.
REQ-016 avm_read  out  1  Avalon-MM read request.
REQ-017 avm_waitrequest  in  1  slave stall.
REQ-018 avm_readdata  in  32  read data, valid in the cycle avm_read=1 and avm_waitrequest=0.

Function
REQ-019 FSM states SHALL be IDLE, RD_ID, RD_TS, FIN.
REQ-020 IDLE: start=1 -> RD_ID next cycle; clear id_ok, ts_ok, timeout_err, id_value, ts_value; set busy.
REQ-021 RD_ID: avm_read=1, avm_address=BASE_ADDR; on avm_waitrequest=0, capture avm_readdata into id_value and go to RD_TS.
REQ-022 RD_TS: avm_read=1, avm_address=BASE_ADDR+4; on avm_waitrequest=0, capture ts_value and go to FIN.
REQ-023 avm_address and avm_read SHALL remain stable while avm_waitrequest=1.
REQ-024 A 16-bit stall counter SHALL clear on entering each read state and increment each cycle avm_waitrequest=1.
REQ-025 If the counter reaches TIMEOUT_CYCLES while avm_waitrequest=1, the FSM SHALL set timeout_err, deassert avm_read, and go to FIN without capturing; the remaining read is skipped.
REQ-026 FIN: done=1 for exactly one cycle; id_ok/ts_ok computed from captured values (forced 0 for any word not captured); busy=0; next state IDLE.
REQ-027 Zero-wait slave: start at cycle 0 -> RD_ID at 1, RD_TS at 2, FIN/done at 3.
REQ-028 start while busy=1 SHALL be ignored; start during the FIN cycle SHALL be ignored.
REQ-029 avm_read SHALL be 0 in IDLE and FIN.
REQ-030 Result outputs SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-031 reset=1 at any rising edge SHALL force IDLE, abort any outstanding read (avm_read=0 next cycle), and clear all outputs, the stall counter, and captured words to 0.
REQ-032 Reset output values: busy=0, done=0, id_ok=0, ts_ok=0, timeout_err=0, id_value=0, ts_value=0, avm_read=0, avm_address=BASE_ADDR.
REQ-033 A start coincident with reset SHALL be ignored.

Structure
REQ-034 A shared package nios_fprint_sysid_pkg SHALL hold the state enumeration, the word offsets (ID_OFS=0, TS_OFS=4) and the default EXPECTED_* constants.
REQ-035 The stall counter SHALL be a sub-module nios_fprint_stall_timer (clear, enable, limit -> expired).

Verification
REQ-036 Zero-wait slave returns 0 then 0x555F66CE; pulse start -> done at cycle 3, id_ok=1, ts_ok=1, timeout_err=0, ts_value=0x555F66CE.
REQ-037 Slave returns 0x00000001 for word 0 -> done with id_ok=0, ts_ok=1, id_value=1.
REQ-038 waitrequest=1 for 3 cycles on each read -> done at cycle 9, both ok, address and read held stable during the stalls.
REQ-039 waitrequest stuck at 1 with TIMEOUT_CYCLES=16 -> timeout_err=1 and done at cycle 18; id_ok=ts_ok=0; avm_address never equals BASE_ADDR+4.
REQ-040 reset asserted while in RD_TS -> next cycle avm_read=0, busy=0, all results 0; a following start completes normally.
REQ-041 Second start pulse while busy -> ignored: exactly one done, and exactly two read handshakes occur.
